syn_job_que_status: RTL
=======================

# syn_job_que_status

Parametrised job-queue status collector for the grapheme pipeline, generalising the single `job_que_empty` flag to `NUM_CHNLS` queues. For each queue it tracks occupancy from push/pop strobes, derives empty/full flags, and records sticky overflow/underflow errors and a high-water mark. All of this is exposed on a local-bus (LB) register port for software polling. It sits between the anti-alias/rasteriser job queues and the LB decoder.

## Interface

Parameters:
- `NUM_CHNLS`, 4, number of monitored queues (1..16).
- `QUE_DEPTH`, 16, capacity of each queue in entries (≥2); `CNT_W = $clog2(QUE_DEPTH+1)`.
- `LB_ADDR_W`, 8, LB address width.
- `LB_DATA_W`, 32, LB data width (≥ max(CNT_W, NUM_CHNLS, 4)).

Ports (one clock; reset is synchronous and active-high):
- `clk_ir` in 1: clock.
- `rst_il` in 1: synchronous reset, active-high.
- `push_i` in NUM_CHNLS: per-queue push strobe, one entry per cycle.
- `pop_i` in NUM_CHNLS: per-queue pop strobe.
- `que_empty_o` out NUM_CHNLS: occupancy == 0.
- `que_full_o` out NUM_CHNLS: occupancy == QUE_DEPTH.
- `all_empty_o` out 1: AND of `que_empty_o`.
- `lb_rd_en_i` in 1: LB read request.
- `lb_wr_en_i` in 1: LB write request.
- `lb_addr_i` in LB_ADDR_W: LB address.
- `lb_wr_data_i` in LB_DATA_W: LB write data.
- `lb_rd_valid_o` out 1: read data valid.
- `lb_rd_data_o` out LB_DATA_W: read data.

## Operation

- Per channel: `occ` (CNT_W), `hwm` (CNT_W), sticky `ovf` and `udf`.
- Counter update per channel and cycle:
  - push only, not full: `occ+1`.
  - push only, full: `occ` is held and `ovf` is set.
  - pop only, not empty: `occ-1`.
  - pop only, empty: `occ` is held and `udf` is set.
  - push and pop together: `occ` is held and no error flag is set, including at empty and at full.
- `hwm` is loaded with the next `occ` whenever next `occ` > `hwm`, in the same cycle as the `occ` update.
- Register map, channel `c` at base `4*c`:
  - +0 `OCC` (RO): `occ`.
  - +1 `HWM`: read returns `hwm`; any write reloads `hwm` with the current `occ`.
  - +2 `STAT`: bit0 empty, bit1 full, bit2 `ovf`, bit3 `udf`. Bits 2 and 3 are write-1-to-clear; other bits are read-only.
  - +3 reserved: reads 0.
- Global address `0xFF` `SUMMARY` (RO): bits[NUM_CHNLS-1:0] = `que_empty_o`, bit 31 = `all_empty_o`.
- Unmapped or reserved addresses read 0 and still assert `lb_rd_valid_o`. Writes to them are ignored.
- Conflicts:
  - A hardware set of `ovf`/`udf` in the same cycle as a W1C write: the set wins.
  - A write to `HWM` in the same cycle as an `occ` increase: `hwm` takes the new `occ`.
  - Read and write in the same cycle are both performed. The read returns the pre-write value.

## Timing

- Flags `que_empty_o`, `que_full_o` and `all_empty_o` are registered. They reflect `occ` one cycle after the strobe cycle.
- LB read latency is 1: `lb_rd_valid_o` is high for exactly the cycle after `lb_rd_en_i`. Data is the state sampled at the `lb_rd_en_i` edge.
- Back-to-back reads are supported, one per cycle.
- LB writes take effect at the clock edge where `lb_wr_en_i` is high.
- Reset values:
  - `occ`, `hwm`, `ovf`, `udf` = 0.
  - `que_empty_o` = all 1, `all_empty_o` = 1, `que_full_o` = 0.
  - `lb_rd_valid_o` = 0, `lb_rd_data_o` = 0.
- Reset asserted mid-operation overrides all strobes and LB accesses in that cycle. A read in flight is dropped: no valid is asserted the next cycle.

## Structure

- Package `syn_job_que_status_pkg`:
  - Register offset constants: `OCC_OFF`, `HWM_OFF`, `STAT_OFF`, `SUMMARY_ADDR`.
  - STAT bit positions.
  - Typedef `chnl_stat_t` struct: `occ`, `hwm`, `ovf`, `udf`.
- Sub-module `syn_que_occ_cntr`: one per channel, instantiated via generate. Owns `occ`, `hwm`, sticky bits and flags, with inputs push, pop, hwm_reload, w1c[1:0].
- The top level holds the address decode and the read mux register.

## Test plan

- Reset, then read `SUMMARY` → `0x8000000F` (NUM_CHNLS=4), valid 1 cycle after `lb_rd_en_i`; `que_full_o` = 0.
- 16 pushes on ch1, then one more push → `OCC` = 16, `que_full_o[1]` = 1, `STAT` = `0x6`, `HWM` = 16.
- Ch0 empty, pop → `STAT` = `0x9`. Write `0x8` to `STAT` → reads `0x1`. W1C in the same cycle as a new underflow → bit3 stays 1.
- Ch2 at occ=3, simultaneous push+pop for 10 cycles → `OCC` = 3, no error bits. Repeat at occ=0 and occ=16 → no flags set.
- Ch3: push to 9, pop to 2, read `HWM` → 9. Write `HWM` → reads 2. Push 1 → reads 3.
- Push ch0 ×5, assert `rst_il` with a read pending → `lb_rd_valid_o` stays 0 the next cycle, `OCC` = 0, `que_empty_o[0]` = 1.

Source files
------------

// File: rtl/syn_job_que_status_pkg.sv
// ============================================================================
// Module   : syn_job_que_status_pkg
// Brief    : Register map constants and per-channel status record for the
//            job-queue status collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package syn_job_que_status_pkg;

    // Counter fields are sized for the largest supported queue depth.
    localparam int MAX_CNT_W = 16;

    localparam logic [1:0] OCC_OFF  = 2'd0;
    localparam logic [1:0] HWM_OFF  = 2'd1;
    localparam logic [1:0] STAT_OFF = 2'd2;
    localparam logic [1:0] RSVD_OFF = 2'd3;

    localparam logic [7:0] SUMMARY_ADDR = 8'hFF;

    localparam int STAT_EMPTY_BIT        = 0;
    localparam int STAT_FULL_BIT         = 1;
    localparam int STAT_OVF_BIT          = 2;
    localparam int STAT_UDF_BIT          = 3;
    localparam int SUMMARY_ALL_EMPTY_BIT = 31;

    typedef struct packed {
        logic [MAX_CNT_W-1:0] occ;
        logic [MAX_CNT_W-1:0] hwm;
        logic                 ovf;
        logic                 udf;
    } chnl_stat_t;

endpackage

`default_nettype wire

// File: rtl/syn_que_occ_cntr.sv
// ============================================================================
// Module   : syn_que_occ_cntr
// Brief    : Single-queue occupancy counter with empty/full flags, sticky
//            overflow/underflow bits and a high-water mark.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syn_que_occ_cntr
    import syn_job_que_status_pkg::*;
#(
    parameter int QUE_DEPTH = 16,
    parameter int CNT_W     = $clog2(QUE_DEPTH + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_hwm_reload,
    input  logic [1:0] i_w1c,
    output chnl_stat_t o_stat,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_empty_nxt
);

    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(QUE_DEPTH);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_hwm;
    logic             r_ovf;
    logic             r_udf;
    logic             r_empty;
    logic             r_full;

    logic [CNT_W-1:0] w_occ_nxt;
    logic [CNT_W-1:0] w_hwm_base;
    logic [CNT_W-1:0] w_hwm_nxt;
    logic             w_ovf_set;
    logic             w_udf_set;

    always_comb begin
        w_occ_nxt = r_occ;
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        // Simultaneous push and pop cancel out, even at the empty/full limits.
        unique case ({i_push, i_pop})
            2'b10: begin
                if (r_occ == c_FULL_CNT) w_ovf_set = 1'b1;
                else                     w_occ_nxt = r_occ + c_ONE;
            end
            2'b01: begin
                if (r_occ == '0) w_udf_set = 1'b1;
                else             w_occ_nxt = r_occ - c_ONE;
            end
            default: ;
        endcase
        w_hwm_base = i_hwm_reload ? r_occ : r_hwm;
        w_hwm_nxt  = (w_occ_nxt > w_hwm_base) ? w_occ_nxt : w_hwm_base;
    end

    assign o_empty_nxt = (w_occ_nxt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ   <= '0;
            r_hwm   <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_hwm   <= w_hwm_nxt;
            // A hardware set beats a software clear in the same cycle.
            r_ovf   <= w_ovf_set | (r_ovf & ~i_w1c[0]);
            r_udf   <= w_udf_set | (r_udf & ~i_w1c[1]);
            r_empty <= (w_occ_nxt == '0);
            r_full  <= (w_occ_nxt == c_FULL_CNT);
        end
    end

    assign o_stat.occ = MAX_CNT_W'(r_occ);
    assign o_stat.hwm = MAX_CNT_W'(r_hwm);
    assign o_stat.ovf = r_ovf;
    assign o_stat.udf = r_udf;
    assign o_empty    = r_empty;
    assign o_full     = r_full;

endmodule

`default_nettype wire

// File: rtl/syn_job_que_status.sv
// ============================================================================
// Module   : syn_job_que_status
// Brief    : Multi-queue job status collector with a local-bus register port
//            (per-channel OCC/HWM/STAT plus a global SUMMARY register).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syn_job_que_status
    import syn_job_que_status_pkg::*;
#(
    parameter int NUM_CHNLS = 4,
    parameter int QUE_DEPTH = 16,
    parameter int LB_ADDR_W = 8,
    parameter int LB_DATA_W = 32
) (
    input  logic                 clk_ir,
    input  logic                 rst_il,
    input  logic [NUM_CHNLS-1:0] push_i,
    input  logic [NUM_CHNLS-1:0] pop_i,
    output logic [NUM_CHNLS-1:0] que_empty_o,
    output logic [NUM_CHNLS-1:0] que_full_o,
    output logic                 all_empty_o,
    input  logic                 lb_rd_en_i,
    input  logic                 lb_wr_en_i,
    input  logic [LB_ADDR_W-1:0] lb_addr_i,
    input  logic [LB_DATA_W-1:0] lb_wr_data_i,
    output logic                 lb_rd_valid_o,
    output logic [LB_DATA_W-1:0] lb_rd_data_o
);

    localparam int CNT_W = $clog2(QUE_DEPTH + 1);
    localparam int CHN_W = LB_ADDR_W - 2;

    logic [CHN_W-1:0]     w_addr_chnl;
    logic [1:0]           w_addr_off;
    logic                 w_is_summary;
    chnl_stat_t           w_stat      [NUM_CHNLS];
    logic [3:0]           w_stat_bits [NUM_CHNLS];
    logic [NUM_CHNLS-1:0] w_empty_nxt;
    logic [31:0]          w_summary32;
    logic [LB_DATA_W-1:0] w_rd_data;
    logic                 w_unused_wr_data;

    logic                 r_all_empty;
    logic                 r_rd_valid;
    logic [LB_DATA_W-1:0] r_rd_data;

    assign w_addr_chnl      = lb_addr_i[LB_ADDR_W-1:2];
    assign w_addr_off       = lb_addr_i[1:0];
    assign w_is_summary     = (lb_addr_i == LB_ADDR_W'(SUMMARY_ADDR));
    assign w_unused_wr_data = ^lb_wr_data_i;

    generate
        for (genvar c = 0; c < NUM_CHNLS; c++) begin : g_chnl
            logic       w_hit;
            logic       w_hwm_reload;
            logic [1:0] w_w1c;

            assign w_hit        = lb_wr_en_i && !w_is_summary && (w_addr_chnl == CHN_W'(c));
            assign w_hwm_reload = w_hit && (w_addr_off == HWM_OFF);
            assign w_w1c        = {2{w_hit && (w_addr_off == STAT_OFF)}}
                                & {lb_wr_data_i[STAT_UDF_BIT], lb_wr_data_i[STAT_OVF_BIT]};

            syn_que_occ_cntr #(
                .QUE_DEPTH (QUE_DEPTH),
                .CNT_W     (CNT_W)
            ) u_cntr (
                .clk          (clk_ir),
                .rst          (rst_il),
                .i_push       (push_i[c]),
                .i_pop        (pop_i[c]),
                .i_hwm_reload (w_hwm_reload),
                .i_w1c        (w_w1c),
                .o_stat       (w_stat[c]),
                .o_empty      (que_empty_o[c]),
                .o_full       (que_full_o[c]),
                .o_empty_nxt  (w_empty_nxt[c])
            );

            always_comb begin
                w_stat_bits[c]                 = '0;
                w_stat_bits[c][STAT_EMPTY_BIT] = que_empty_o[c];
                w_stat_bits[c][STAT_FULL_BIT]  = que_full_o[c];
                w_stat_bits[c][STAT_OVF_BIT]   = w_stat[c].ovf;
                w_stat_bits[c][STAT_UDF_BIT]   = w_stat[c].udf;
            end
        end
    endgenerate

    always_comb begin
        w_summary32                        = 32'(que_empty_o);
        w_summary32[SUMMARY_ALL_EMPTY_BIT] = r_all_empty;
    end

    // Read data reflects state before any write landing on the same edge.
    always_comb begin
        w_rd_data = '0;
        if (w_is_summary) begin
            w_rd_data = LB_DATA_W'(w_summary32);
        end else begin
            for (int c = 0; c < NUM_CHNLS; c++) begin
                if (w_addr_chnl == CHN_W'(c)) begin
                    unique case (w_addr_off)
                        OCC_OFF:  w_rd_data = LB_DATA_W'(w_stat[c].occ);
                        HWM_OFF:  w_rd_data = LB_DATA_W'(w_stat[c].hwm);
                        STAT_OFF: w_rd_data = LB_DATA_W'(w_stat_bits[c]);
                        default:  w_rd_data = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            r_all_empty <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_all_empty <= &w_empty_nxt;
            r_rd_valid  <= lb_rd_en_i;
            if (lb_rd_en_i) begin
                r_rd_data <= w_rd_data;
            end
        end
    end

    assign all_empty_o   = r_all_empty;
    assign lb_rd_valid_o = r_rd_valid;
    assign lb_rd_data_o  = r_rd_data;

endmodule

`default_nettype wire
